// File: rtl/hz_pkg.sv
// Shared stage indices, miss-FSM states and the redirect priority selector.
// Pure declarations; no timing or flow control of its own.
package hz_pkg;

    localparam int ST_IF  = 0;
    localparam int ST_ID  = 1;
    localparam int ST_EX  = 2;
    localparam int ST_MEM = 3;
    localparam int ST_WB  = 4;

    localparam int MAX_REDIR   = 8;
    localparam int REDIR_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } miss_st_e;

    // Oldest instruction wins (highest stage); strict compare keeps the lower index on ties.
    function automatic logic [REDIR_IDX_W-1:0] prio_sel(
        input logic [MAX_REDIR-1:0]   vld,
        input logic [3*MAX_REDIR-1:0] stg
    );
        logic                   found;
        logic [2:0]             best;
        logic [REDIR_IDX_W-1:0] idx;
        found = 1'b0;
        best  = 3'd0;
        idx   = '0;
        for (int k = 0; k < MAX_REDIR; k++) begin
            if (vld[k] && (!found || (stg[3*k +: 3] > best))) begin
                found = 1'b1;
                best  = stg[3*k +: 3];
                idx   = REDIR_IDX_W'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/miss_tracker.sv
// Registered cache-miss tracker; busy asserts the same cycle a miss is seen.
// No backpressure: the fill's ready pulse is the only way out of MISS/DRAIN.
module miss_tracker
    import hz_pkg::*;
#(
    parameter bit EN_DRAIN = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_req,
    input  logic     i_hit,
    input  logic     i_ready,
    input  logic     i_redir_acc,
    output miss_st_e o_state,
    output logic     o_busy,
    output logic     o_capture,
    output logic     o_drain_done
);

    miss_st_e r_state;
    miss_st_e w_state_nxt;
    logic     w_miss_now;

    assign w_miss_now = i_req & ~i_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_capture    = 1'b0;
        o_drain_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_miss_now) begin
                    w_state_nxt = MISS;
                end
            end
            MISS: begin
                // A redirect coinciding with the fill return is issued live, so no DRAIN.
                if (i_ready) begin
                    w_state_nxt = IDLE;
                end else if (EN_DRAIN && i_redir_acc) begin
                    w_state_nxt = DRAIN;
                    o_capture   = 1'b1;
                end
            end
            DRAIN: begin
                if (i_ready) begin
                    w_state_nxt  = IDLE;
                    o_drain_done = 1'b1;
                end else if (i_redir_acc) begin
                    o_capture = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_state = r_state;
    assign o_busy  = (r_state != IDLE) | w_miss_now;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Per-stage stall/bubble generation, redirect arbitration and I-fill redirect replay.
// Zero-latency combinational outputs; counters lag one cycle; held redirects wait for the pipe.
module pipe_hazard_ctrl
    import hz_pkg::*;
#(
    parameter int                    NSTAGE      = 5,
    parameter int                    XLEN        = 32,
    parameter int                    NREDIR      = 2,
    parameter logic [3*NREDIR-1:0]   REDIR_STAGE = {3'd2, 3'd1},
    parameter int                    LU_STAGE    = 1,
    parameter int                    CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREDIR-1:0]      redir_valid_i,
    input  logic [NREDIR*XLEN-1:0] redir_pc_i,
    input  logic                   load_use_i,
    input  logic                   if_req_i,
    input  logic                   icache_hit_i,
    input  logic                   ic_ready_i,
    input  logic                   ex_req_i,
    input  logic                   dcache_hit_i,
    input  logic                   dc_ready_i,
    input  logic                   wait_i,
    output logic [NSTAGE-1:0]      stall_o,
    output logic [NSTAGE-1:0]      bubble_o,
    output logic                   jump_flag_o,
    output logic [XLEN-1:0]        jump_pc_o,
    output logic                   ic_drop_o,
    output logic [CNT_W-1:0]       stall_cnt_o,
    output logic [CNT_W-1:0]       redir_cnt_o
);

    miss_st_e w_ic_state;
    miss_st_e w_dc_state;
    logic     w_ic_busy;
    logic     w_dc_busy;
    logic     w_ic_cap;
    logic     w_ic_drain_done;
    logic     w_dc_cap_unused;
    logic     w_dc_done_unused;

    logic [REDIR_IDX_W-1:0] w_win_idx;
    logic [2:0]             w_win_stg;
    logic [XLEN-1:0]        w_win_tgt;
    logic                   w_any_redir;
    logic                   w_blocked;
    logic                   w_acc;
    logic                   w_live_jump;
    logic                   w_freeze;

    logic [NSTAGE-1:0] w_stall_base;
    logic [NSTAGE-1:0] w_stall;
    logic [NSTAGE-1:0] w_bubble;
    logic              w_jump;
    logic [XLEN-1:0]   w_jump_pc;

    logic [XLEN-1:0]  r_pend_pc;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_redir_cnt;

    miss_tracker #(.EN_DRAIN(1'b1)) u_ic_trk (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (if_req_i),
        .i_hit        (icache_hit_i),
        .i_ready      (ic_ready_i),
        .i_redir_acc  (w_acc),
        .o_state      (w_ic_state),
        .o_busy       (w_ic_busy),
        .o_capture    (w_ic_cap),
        .o_drain_done (w_ic_drain_done)
    );

    miss_tracker #(.EN_DRAIN(1'b0)) u_dc_trk (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (ex_req_i),
        .i_hit        (dcache_hit_i),
        .i_ready      (dc_ready_i),
        .i_redir_acc  (1'b0),
        .o_state      (w_dc_state),
        .o_busy       (w_dc_busy),
        .o_capture    (w_dc_cap_unused),
        .o_drain_done (w_dc_done_unused)
    );

    assign w_freeze    = wait_i | w_dc_busy;
    assign w_any_redir = |redir_valid_i;
    assign w_win_idx   = prio_sel(MAX_REDIR'(redir_valid_i), (3*MAX_REDIR)'(REDIR_STAGE));

    always_comb begin
        w_win_stg = 3'd0;
        w_win_tgt = '0;
        for (int k = 0; k < NREDIR; k++) begin
            if (REDIR_IDX_W'(k) == w_win_idx) begin
                w_win_stg = REDIR_STAGE[3*k +: 3];
                w_win_tgt = redir_pc_i[XLEN*k +: XLEN];
            end
        end
    end

    // I-busy is deliberately left out: a redirect may land while IF waits on a fill.
    always_comb begin
        w_stall_base = '0;
        if (w_freeze) begin
            w_stall_base = '1;
        end else if (load_use_i) begin
            for (int i = 0; i < LU_STAGE; i++) begin
                w_stall_base[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_blocked = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (i == int'(w_win_stg)) begin
                w_blocked = w_stall_base[i];
            end
        end
    end

    assign w_acc       = w_any_redir & ~w_blocked;
    assign w_live_jump = w_acc & ~w_ic_cap;

    always_comb begin
        w_stall = w_stall_base;
        if (w_ic_busy) begin
            w_stall[0] = 1'b1;
        end
    end

    always_comb begin
        w_bubble = '0;
        if (!w_freeze) begin
            if (load_use_i && !(w_acc && (int'(w_win_stg) > LU_STAGE))) begin
                w_bubble[LU_STAGE] = 1'b1;
            end
            if (w_acc) begin
                for (int i = 0; i < NSTAGE; i++) begin
                    if (i < int'(w_win_stg)) begin
                        w_bubble[i] = 1'b1;
                    end
                end
            end
        end
    end

    // A live redirect in the drain-return cycle is younger than pend_pc, so it takes precedence.
    always_comb begin
        w_jump    = w_live_jump | w_ic_drain_done;
        w_jump_pc = '0;
        if (w_live_jump) begin
            w_jump_pc = w_win_tgt;
        end else if (w_ic_drain_done) begin
            w_jump_pc = r_pend_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_pc   <= '0;
            r_stall_cnt <= '0;
            r_redir_cnt <= '0;
        end else begin
            if (w_ic_cap) begin
                r_pend_pc <= w_win_tgt;
            end
            if (w_stall[0] && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_acc && (r_redir_cnt != '1)) begin
                r_redir_cnt <= r_redir_cnt + 1'b1;
            end
        end
    end

    assign stall_o     = rst_n ? w_stall : '0;
    assign bubble_o    = rst_n ? w_bubble : '0;
    assign jump_flag_o = rst_n & w_jump;
    assign jump_pc_o   = rst_n ? w_jump_pc : '0;
    assign ic_drop_o   = rst_n & w_ic_drain_done;
    assign stall_cnt_o = r_stall_cnt;
    assign redir_cnt_o = r_redir_cnt;

endmodule
